// File: rtl/aoi_pkg.sv
// Shared types and constants for the two-stage AND-OR-INVERT / OR-AND-INVERT pipeline.
package aoi_pkg;

  typedef enum logic {
    AOI_MODE = 1'b0,
    OAI_MODE = 1'b1
  } mode_e;

  localparam int ZCNT_W = 16;

  function automatic logic [ZCNT_W-1:0] sat_inc(input logic [ZCNT_W-1:0] v);
    return (v == {ZCNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/aoi_stage.sv
// One valid/ready pipeline register, 1-cycle latency, full throughput.
// Stalls by holding its payload while downstream is not ready; refills in the cycle it drains.
module aoi_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  assign in_ready = ~out_valid | out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= in_data;
      end
    end
  end

endmodule

// File: rtl/aoi_pipe.sv
// Two-stage AOI/OAI evaluator: terms registered in stage 1, reduce+invert registered in stage 2 (2-cycle latency).
// Valid/ready throughout; stalls propagate back so at most two beats are held; counts delivered zero results.
module aoi_pipe
  import aoi_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int TERMS = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [TERMS*WIDTH-1:0] in_a,
  input  logic [TERMS*WIDTH-1:0] in_b,
  input  logic               in_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_g,
  output logic [ZCNT_W-1:0]  zero_cnt
);

  localparam int S1_W = TERMS * WIDTH + 1;

  if (TERMS < 2 || TERMS > 8) begin : g_bad_terms
    $error("aoi_pipe: TERMS must lie in 2..8");
  end

  logic                   armed;
  logic                   s1_in_valid;
  logic                   s1_in_ready;
  logic [TERMS*WIDTH-1:0] terms;
  logic [S1_W-1:0]        s1_in_data;
  logic                   s1_valid;
  logic                   s2_in_ready;
  logic [S1_W-1:0]        s1_data;
  mode_e                  s1_mode;
  logic [WIDTH-1:0]       reduced;
  logic [WIDTH-1:0]       s2_in_data;

  // Input stays closed until the first edge after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed <= 1'b0;
    end else begin
      armed <= 1'b1;
    end
  end

  assign s1_in_valid = in_valid & armed;
  assign in_ready    = s1_in_ready & armed;

  always_comb begin
    terms = '0;
    for (int k = 0; k < TERMS; k++) begin
      if (mode_e'(in_mode) == OAI_MODE) begin
        terms[k*WIDTH +: WIDTH] = in_a[k*WIDTH +: WIDTH] | in_b[k*WIDTH +: WIDTH];
      end else begin
        terms[k*WIDTH +: WIDTH] = in_a[k*WIDTH +: WIDTH] & in_b[k*WIDTH +: WIDTH];
      end
    end
  end

  assign s1_in_data = {in_mode, terms};

  aoi_stage #(.W(S1_W)) u_stage1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s1_in_valid),
    .in_ready  (s1_in_ready),
    .in_data   (s1_in_data),
    .out_valid (s1_valid),
    .out_ready (s2_in_ready),
    .out_data  (s1_data)
  );

  assign s1_mode = mode_e'(s1_data[S1_W-1]);

  // OAI reduces with AND (identity all-ones), AOI with OR (identity zero).
  always_comb begin
    reduced = (s1_mode == OAI_MODE) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
    for (int k = 0; k < TERMS; k++) begin
      if (s1_mode == OAI_MODE) begin
        reduced = reduced & s1_data[k*WIDTH +: WIDTH];
      end else begin
        reduced = reduced | s1_data[k*WIDTH +: WIDTH];
      end
    end
  end

  assign s2_in_data = ~reduced;

  aoi_stage #(.W(WIDTH)) u_stage2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s1_valid),
    .in_ready  (s2_in_ready),
    .in_data   (s2_in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_g)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero_cnt <= '0;
    end else if (out_valid && out_ready && (out_g == '0)) begin
      zero_cnt <= sat_inc(zero_cnt);
    end
  end

endmodule

// File: doc/aoi_pipe.md
AOI_PIPE -- requirements
Module: aoi_pipe

Interface
REQ-001 Parameter WIDTH, default 8: bit width of each operand and of the result.
REQ-002 Parameter TERMS, default 2, legal range 2..8: number of two-operand terms combined per evaluation.
REQ-003 Port clk  input  1: single clock; all state updates on rising edge.
REQ-004 Port rst  input  1: reset, asynchronous, active-high.
REQ-005 Port in_valid  input  1: upstream beat present.
REQ-006 Port in_ready  output  1: block accepts a beat this cycle.
REQ-007 Port in_a  input  TERMS*WIDTH: term operands A; term k occupies bits [k*WIDTH +: WIDTH].
REQ-008 Port in_b  input  TERMS*WIDTH: term operands B, same packing as in_a.
REQ-009 Port in_mode  input  1: 0 = AOI, 1 = OAI; captured with the beat.
REQ-010 Port out_valid  output  1: result beat present.
REQ-011 Port out_ready  input  1: downstream accepts the result.
REQ-012 Port out_g  output  WIDTH: result.
REQ-013 Port zero_cnt  output  16: count of delivered results equal to zero, saturating.

Function
REQ-014 AOI mode SHALL give out_g = ~(OR over k of (a_k & b_k)), bitwise.
REQ-015 OAI mode SHALL give out_g = ~(AND over k of (a_k | b_k)), bitwise.
REQ-016 Stage 1 SHALL register the per-term results (AND or OR by mode), the mode, and a valid bit.
REQ-017 Stage 2 SHALL register the reduction and inversion of the stage-1 terms, plus a valid bit.
REQ-018 Minimum latency SHALL be 2 cycles, from the accepting edge to out_valid high.
REQ-019 Sustained throughput SHALL be 1 beat per cycle while out_ready stays high.
REQ-020 A beat transfers on an input or output port only when valid and ready are both high on the same edge.
REQ-021 in_ready SHALL be high when stage 1 is empty, or when stage 1 moves to stage 2 in the same cycle.
REQ-022 Stage 2 SHALL load when it is empty or when out_ready is high; otherwise it holds.
REQ-023 Under backpressure: out_g and out_valid stable while out_valid=1 and out_ready=0; no beat lost, duplicated or reordered.
REQ-024 At most 2 beats SHALL be in flight.
REQ-025 in_valid arriving together with a full, stalled pipeline SHALL not be accepted (in_ready=0).
REQ-026 in_a, in_b and in_mode are don't-care while in_valid=0.
REQ-027 zero_cnt SHALL increment by 1 on each output transfer with out_g == 0.
REQ-028 zero_cnt SHALL hold at 0xFFFF once reached.
REQ-029 Mode SHALL travel with its beat; mixed-mode back-to-back beats each use their own mode.

Reset
REQ-030 rst high SHALL immediately clear both stage valids and zero_cnt, independent of clk.
REQ-031 While rst is high: out_valid=0, in_ready=0, out_g=0, zero_cnt=0.
REQ-032 Beats in flight when rst asserts SHALL be discarded.
REQ-033 in_ready SHALL go high on the first clk edge after rst deasserts.

Structure
REQ-034 Package aoi_pkg SHALL hold the mode enum (AOI_MODE=0, OAI_MODE=1) and the constant ZCNT_W=16.
REQ-035 A sub-module aoi_stage (parametrised payload width, valid/ready pipeline register) SHALL be instantiated once per stage.
REQ-036 TERMS outside 2..8 SHALL raise an elaboration-time error.

Verification (WIDTH=8, TERMS=2)
REQ-037 AOI: a=(0xF0,0x0F), b=(0xFF,0x00), out_ready=1 -> out_g=0x0F two cycles after acceptance.
REQ-038 OAI: a=(0xF0,0x03), b=(0x0C,0x00) -> out_g=0xFF; next beat AOI with all operands 0xFF -> out_g=0x00 and zero_cnt=1.
REQ-039 Backpressure: out_ready=0, offer 3 beats -> 2 accepted, in_ready=0 on the third; raise out_ready -> all 3 delivered in order, out_g stable while stalled.
REQ-040 Saturation: preload zero_cnt to 0xFFFE by delivering 65534 zero results, then 3 more zero results -> zero_cnt=0xFFFF.
REQ-041 Reset mid-operation: both stages full and stalled, pulse rst between clock edges -> out_valid=0 and zero_cnt=0 immediately; first beat after release has 2-cycle latency.
REQ-042 Streaming: 100 random mixed-mode beats with out_ready toggling randomly -> every output matches a scoreboard model in order.
